// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the GCore instruction fetch/issue sequencer.
//   state_e : fetch/issue FSM state encoding (also exported on the debug port)
//   OP_NOP  : opcode presented to the decoder whenever no instruction is issued
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_ISSUE = 2'd2
    } state_e;

    localparam logic [7:0] OP_NOP = 8'h00;

endpackage

// File: rtl/fetch_unit_if.sv
// Bus bundle between the fetch unit, instruction memory and decoder/datapath.
//   imem_req/imem_addr  -> memory   request, address held stable until imem_ack
//   imem_ack/imem_rdata <- memory   word returned in the cycle imem_ack is high
//   op/operand/pc       -> decoder  issued instruction fields and its address
//   ins_valid           -> datapath instruction is presented for execution
//   ins_ready           <- datapath instruction completes (retires) this cycle
//   jump/branch/acc_zero <- decoder/datapath redirect inputs, used at retire
//
// Handshakes: a transfer happens on a rising edge where both sides are high
// (imem_req & imem_ack, ins_valid & ins_ready). The initiator keeps its
// request and payload stable until that edge; ack/ready seen while the
// request is low are ignored. Ack/ready may be high in the same cycle the
// request first rises.
interface fetch_unit_if #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16
);
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;
    logic [7:0]         op;
    logic [7:0]         operand;
    logic [ADDR_W-1:0]  pc;
    logic               ins_valid;
    logic               ins_ready;
    logic               jump;
    logic               branch;
    logic               acc_zero;

    // Fetch unit side
    modport master (
        output imem_req, imem_addr, op, operand, pc, ins_valid,
        input  imem_ack, imem_rdata, ins_ready, jump, branch, acc_zero
    );

    // Memory / decoder / datapath side
    modport slave (
        input  imem_req, imem_addr, op, operand, pc, ins_valid,
        output imem_ack, imem_rdata, ins_ready, jump, branch, acc_zero
    );
endinterface

// File: rtl/fetch_unit_pc_next.sv
// Combinational next-PC select for the fetch unit.
//   pc_i       : address of the instruction being retired
//   operand_i  : target field of that instruction
//   jump_i     : unconditional jump (has priority over branch)
//   branch_i   : BZ instruction, taken when acc_zero_i is high
//   acc_zero_i : accumulator equals zero
//   npc_o      : next fetch address
module fetch_unit_pc_next #(
    parameter int ADDR_W = 8
) (
    input  logic [ADDR_W-1:0] pc_i,
    input  logic [7:0]        operand_i,
    input  logic              jump_i,
    input  logic              branch_i,
    input  logic              acc_zero_i,
    output logic [ADDR_W-1:0] npc_o
);
    logic [ADDR_W-1:0] target;

    assign target = ADDR_W'(operand_i);

    always_comb begin
        // Sequential increment wraps naturally at 2^ADDR_W
        npc_o = pc_i + ADDR_W'(1);
        if (jump_i) begin
            npc_o = target;
        end else if (branch_i && acc_zero_i) begin
            npc_o = target;
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// GCore instruction fetch/issue sequencer.
// Fetches one {op,operand} word from instruction memory, presents it to the
// decoder/datapath until it retires, then redirects the PC and fetches again.
//   clk, rst_n   : clock, asynchronous active-low reset
//   bus          : fetch_unit_if.master (memory request, issue handshake,
//                  redirect inputs)
//   retire_cnt   : wrapping count of retired instructions
//   dbg_state_o  : current FSM state for observation
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    fetch_unit_if.master     bus,
    output logic [CNT_W-1:0] retire_cnt,
    output state_e           dbg_state_o
);
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [7:0]        op_q, op_d;
    logic [7:0]        operand_q, operand_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] npc;

    fetch_unit_pc_next #(
        .ADDR_W (ADDR_W)
    ) u_pc_next (
        .pc_i       (pc_q),
        .operand_i  (operand_q),
        .jump_i     (bus.jump),
        .branch_i   (bus.branch),
        .acc_zero_i (bus.acc_zero),
        .npc_o      (npc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            op_q      <= OP_NOP;
            operand_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            op_q      <= op_d;
            operand_q <= operand_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        op_d      = op_q;
        operand_d = operand_q;
        cnt_d     = cnt_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (bus.imem_ack) begin
                    op_d      = bus.imem_rdata[INSTR_W-1 -: 8];
                    operand_d = bus.imem_rdata[7:0];
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // Redirect inputs only matter here, at the retire edge
                if (bus.ins_ready) begin
                    pc_d    = npc;
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Request and valid decode straight from the state register so the async
    // reset drops them in the same cycle it is asserted.
    assign bus.imem_req  = (state_q == S_FETCH);
    assign bus.imem_addr = pc_q;
    assign bus.ins_valid = (state_q == S_ISSUE);
    // The latched opcode is kept across retire; the decoder sees NOP instead.
    assign bus.op        = (state_q == S_ISSUE) ? op_q : OP_NOP;
    assign bus.operand   = operand_q;
    assign bus.pc        = pc_q;
    assign retire_cnt    = cnt_q;
    assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized run checked
// against an architectural model (PC sequence, issued words, retire count).
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int ADDR_W   = 8;
  localparam int INSTR_W  = 16;
  localparam int CNT_W    = 16;
  localparam int CNT_S_W  = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus ();
  fetch_unit_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus_s ();

  logic [CNT_W-1:0]   retire_cnt;
  logic [CNT_S_W-1:0] retire_cnt_s;
  state_e             dbg_state;
  state_e             dbg_state_s;

  fetch_unit #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .retire_cnt  (retire_cnt),
    .dbg_state_o (dbg_state)
  );

  // Narrow-counter copy fed identical inputs, to reach counter wrap quickly
  fetch_unit #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .CNT_W(CNT_S_W)) dut_s (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus_s),
    .retire_cnt  (retire_cnt_s),
    .dbg_state_o (dbg_state_s)
  );

  assign bus_s.imem_ack   = bus.imem_ack;
  assign bus_s.imem_rdata = bus.imem_rdata;
  assign bus_s.ins_ready  = bus.ins_ready;
  assign bus_s.jump       = bus.jump;
  assign bus_s.branch     = bus.branch;
  assign bus_s.acc_zero   = bus.acc_zero;

  int checks = 0;
  int errors = 0;

  // ---------------- instruction memory model ----------------
  logic [INSTR_W-1:0] mem [256];
  int mem_delay = 0;   // wait cycles before ack in fixed mode
  bit mem_rand  = 0;   // random ack each requesting cycle
  bit stray_ack = 0;   // drive ack while no request is pending
  int wait_cnt  = 0;

  initial begin
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        bus.imem_ack = 1'b0;
        wait_cnt     = 0;
      end else if (bus.imem_req) begin
        bit go;
        if (mem_rand) go = ($urandom_range(0, 2) == 0);
        else          go = (wait_cnt >= mem_delay);
        if (go) begin
          bus.imem_ack   = 1'b1;
          bus.imem_rdata = mem[bus.imem_addr];
          wait_cnt       = 0;
        end else begin
          bus.imem_ack   = 1'b0;
          bus.imem_rdata = INSTR_W'($urandom);
          wait_cnt++;
        end
      end else begin
        bus.imem_ack   = stray_ack;
        bus.imem_rdata = 16'hDEAD;
        wait_cnt       = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = '0;
  endtask

  task automatic drive_idle();
    bus.ins_ready = 1'b0;
    bus.jump      = 1'b0;
    bus.branch    = 1'b0;
    bus.acc_zero  = 1'b0;
    stray_ack     = 1'b0;
  endtask

  // Leaves the DUT in S_IDLE with rst_n just released
  task automatic do_reset();
    rst_n = 1'b0;
    drive_idle();
    step();
    step();
    rst_n = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    clear_mem();
    mem_rand = 0;
    mem_delay = 0;
    rst_n = 1'b0;
    drive_idle();
    step();
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %0b expected 0", bus.imem_req); end
    checks++; if (bus.ins_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", bus.ins_valid); end
    checks++; if (bus.op !== 8'h00) begin errors++; $display("FAIL reset_op: got %h expected 00", bus.op); end
    checks++; if (bus.operand !== 8'h00) begin errors++; $display("FAIL reset_operand: got %h expected 00", bus.operand); end
    checks++; if (bus.pc !== 8'h00) begin errors++; $display("FAIL reset_pc: got %h expected 00", bus.pc); end
    checks++; if (retire_cnt !== 16'h0000) begin errors++; $display("FAIL reset_cnt: got %h expected 0000", retire_cnt); end
    checks++; if (dbg_state !== S_IDLE || dbg_state_s !== S_IDLE) begin errors++; $display("FAIL reset_state: got %0d/%0d expected %0d", dbg_state, dbg_state_s, S_IDLE); end
    rst_n = 1'b1;
    step();
    // one edge after release: IDLE -> FETCH
    checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL reset_first_fetch: req got %0b expected 1", bus.imem_req); end
  endtask

  task automatic test_basic();
    logic [INSTR_W-1:0] exp_q [$];
    logic [ADDR_W-1:0]  exp_addr;
    logic [INSTR_W-1:0] w;
    clear_mem();
    mem[0] = 16'h4005;
    mem[1] = 16'h0000;
    mem_delay = 0;
    do_reset();
    bus.ins_ready = 1'b1;
    exp_q = {mem[0], mem[1]};
    exp_addr = '0;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== exp_addr) begin errors++; $display("FAIL basic_fetch[%0d]: req %0b addr %h expected 1 %h", i, bus.imem_req, bus.imem_addr, exp_addr); end
      checks++; if (bus.ins_valid !== 1'b0 || bus.op !== 8'h00) begin errors++; $display("FAIL basic_nop[%0d]: valid %0b op %h expected 0 00", i, bus.ins_valid, bus.op); end
      checks++; if (retire_cnt !== CNT_W'(i)) begin errors++; $display("FAIL basic_cnt[%0d]: got %0d expected %0d", i, retire_cnt, i); end
      step();
      w = exp_q.pop_front();
      checks++; if (bus.ins_valid !== 1'b1 || bus.op !== w[15:8] || bus.operand !== w[7:0] || bus.pc !== exp_addr) begin errors++; $display("FAIL basic_issue[%0d]: valid %0b op %h operand %h pc %h expected 1 %h %h %h", i, bus.ins_valid, bus.op, bus.operand, bus.pc, w[15:8], w[7:0], exp_addr); end
      checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL basic_req_drop[%0d]: got %0b expected 0", i, bus.imem_req); end
      exp_addr = exp_addr + 8'd1;
    end
    step();
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h02) begin errors++; $display("FAIL basic_fetch2: req %0b addr %h expected 1 02", bus.imem_req, bus.imem_addr); end
    checks++; if (retire_cnt !== 16'd2) begin errors++; $display("FAIL basic_cnt2: got %0d expected 2", retire_cnt); end
  endtask

  task automatic test_ack_delay();
    clear_mem();
    mem[0] = 16'hA55A;
    mem_delay = 3;
    do_reset();
    bus.ins_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h00) begin errors++; $display("FAIL delay_hold[%0d]: req %0b addr %h expected 1 00", i, bus.imem_req, bus.imem_addr); end
      checks++; if (bus.ins_valid !== 1'b0 || bus.op !== 8'h00) begin errors++; $display("FAIL delay_novalid[%0d]: valid %0b op %h expected 0 00", i, bus.ins_valid, bus.op); end
    end
    step();
    checks++; if (bus.ins_valid !== 1'b1 || bus.op !== 8'hA5 || bus.operand !== 8'h5A) begin errors++; $display("FAIL delay_issue: valid %0b op %h operand %h expected 1 a5 5a", bus.ins_valid, bus.op, bus.operand); end
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL delay_req_drop: got %0b expected 0", bus.imem_req); end
    step();
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h01) begin errors++; $display("FAIL delay_next: req %0b addr %h expected 1 01", bus.imem_req, bus.imem_addr); end
    mem_delay = 0;
  endtask

  task automatic test_stall();
    clear_mem();
    mem[0] = 16'h3C7E;
    mem_delay = 0;
    do_reset();
    step();
    step();
    stray_ack = 1'b1;
    for (int i = 0; i < 6; i++) begin
      checks++; if (bus.ins_valid !== 1'b1 || bus.op !== 8'h3C || bus.operand !== 8'h7E || bus.pc !== 8'h00) begin errors++; $display("FAIL stall_hold[%0d]: valid %0b op %h operand %h pc %h expected 1 3c 7e 00", i, bus.ins_valid, bus.op, bus.operand, bus.pc); end
      checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL stall_nofetch[%0d]: req %0b expected 0", i, bus.imem_req); end
      if (i == 5) begin
        bus.ins_ready = 1'b1;
        stray_ack = 1'b0;
      end
      step();
    end
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h01 || bus.ins_valid !== 1'b0) begin errors++; $display("FAIL stall_retire: req %0b addr %h valid %0b expected 1 01 0", bus.imem_req, bus.imem_addr, bus.ins_valid); end
    checks++; if (retire_cnt !== 16'd1) begin errors++; $display("FAIL stall_cnt: got %0d expected 1", retire_cnt); end
  endtask

  task automatic test_redirect();
    // {jump, branch, acc_zero} at retire and the address that must follow
    logic [2:0]        ctl  [5] = '{3'b100, 3'b011, 3'b010, 3'b110, 3'b001};
    logic [ADDR_W-1:0] nxt  [5] = '{8'h20, 8'h30, 8'h31, 8'h50, 8'h51};
    logic [ADDR_W-1:0] cur;
    clear_mem();
    mem[8'h00] = 16'h0120;
    mem[8'h20] = 16'hF030;
    mem[8'h30] = 16'hF040;
    mem[8'h31] = 16'h0150;
    mem[8'h50] = 16'h2211;
    mem_delay = 0;
    do_reset();
    bus.ins_ready = 1'b1;
    cur = 8'h00;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== cur) begin errors++; $display("FAIL redirect_fetch[%0d]: req %0b addr %h expected 1 %h", i, bus.imem_req, bus.imem_addr, cur); end
      // opposite values while fetching must have no effect
      {bus.jump, bus.branch, bus.acc_zero} = ~ctl[i];
      step();
      checks++; if (bus.ins_valid !== 1'b1 || bus.op !== mem[cur][15:8] || bus.pc !== cur) begin errors++; $display("FAIL redirect_issue[%0d]: valid %0b op %h pc %h expected 1 %h %h", i, bus.ins_valid, bus.op, bus.pc, mem[cur][15:8], cur); end
      {bus.jump, bus.branch, bus.acc_zero} = ctl[i];
      cur = nxt[i];
    end
    step();
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== cur) begin errors++; $display("FAIL redirect_last: req %0b addr %h expected 1 %h", bus.imem_req, bus.imem_addr, cur); end
    drive_idle();
  endtask

  task automatic test_wrap();
    logic [ADDR_W-1:0] cur;
    clear_mem();
    mem[8'h00] = 16'h01FF;
    mem[8'hFF] = 16'h2222;
    mem_delay = 0;
    do_reset();
    bus.ins_ready = 1'b1;
    cur = 8'h00;
    for (int i = 0; i < 16; i++) begin
      step();
      checks++; if (bus.imem_addr !== cur || bus.imem_req !== 1'b1) begin errors++; $display("FAIL wrap_fetch[%0d]: req %0b addr %h expected 1 %h", i, bus.imem_req, bus.imem_addr, cur); end
      if (i == 15) begin
        checks++; if (retire_cnt_s !== 4'hF) begin errors++; $display("FAIL wrap_cnt_pre: got %h expected f", retire_cnt_s); end
      end
      step();
      bus.jump = (cur == 8'h00);
      cur = (cur == 8'h00) ? 8'hFF : 8'h00;
    end
    step();
    checks++; if (bus.imem_addr !== 8'h00) begin errors++; $display("FAIL wrap_pc: got %h expected 00", bus.imem_addr); end
    checks++; if (retire_cnt_s !== 4'h0) begin errors++; $display("FAIL wrap_cnt: got %h expected 0", retire_cnt_s); end
    checks++; if (retire_cnt !== 16'd16) begin errors++; $display("FAIL wrap_cnt_wide: got %0d expected 16", retire_cnt); end
    drive_idle();
  endtask

  task automatic test_reset_mid();
    clear_mem();
    mem[0] = 16'h1111;
    mem[1] = 16'h2222;
    // mid-fetch
    mem_delay = 5;
    do_reset();
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.imem_req !== 1'b0 || bus.ins_valid !== 1'b0) begin errors++; $display("FAIL rstmid_fetch: req %0b valid %0b expected 0 0", bus.imem_req, bus.ins_valid); end
    // mid-issue at pc=1
    mem_delay = 0;
    do_reset();
    bus.ins_ready = 1'b1;
    step();
    step();
    step();
    bus.ins_ready = 1'b0;
    step();
    checks++; if (bus.ins_valid !== 1'b1 || bus.pc !== 8'h01) begin errors++; $display("FAIL rstmid_pre: valid %0b pc %h expected 1 01", bus.ins_valid, bus.pc); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.ins_valid !== 1'b0 || bus.imem_req !== 1'b0 || bus.pc !== 8'h00 || bus.op !== 8'h00) begin errors++; $display("FAIL rstmid_issue: valid %0b req %0b pc %h op %h expected 0 0 00 00", bus.ins_valid, bus.imem_req, bus.pc, bus.op); end
    step();
    rst_n = 1'b1;
    step();
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h00) begin errors++; $display("FAIL rstmid_restart: req %0b addr %h expected 1 00", bus.imem_req, bus.imem_addr); end
  endtask

  task automatic test_random();
    logic [ADDR_W-1:0] m_pc;
    int unsigned       m_cnt;
    int                retired;
    int                cycles;
    logic [INSTR_W-1:0] w;
    bit r, j, b, z;
    for (int i = 0; i < 256; i++) mem[i] = INSTR_W'($urandom);
    mem_rand = 1;
    do_reset();
    m_pc = '0;
    m_cnt = 0;
    retired = 0;
    cycles = 0;
    while (retired < 200 && cycles < 5000) begin
      step();
      cycles++;
      w = mem[m_pc];
      checks++; if (bus.imem_req === 1'b1 && bus.ins_valid === 1'b1) begin errors++; $display("FAIL rand_excl: req and valid both high at cycle %0d", cycles); end
      if (bus.imem_req === 1'b1) begin
        checks++; if (bus.imem_addr !== m_pc) begin errors++; $display("FAIL rand_addr: got %h expected %h", bus.imem_addr, m_pc); end
      end
      if (bus.ins_valid === 1'b1) begin
        checks++; if (bus.op !== w[15:8] || bus.operand !== w[7:0] || bus.pc !== m_pc) begin errors++; $display("FAIL rand_issue: op %h operand %h pc %h expected %h %h %h", bus.op, bus.operand, bus.pc, w[15:8], w[7:0], m_pc); end
      end else begin
        checks++; if (bus.op !== 8'h00) begin errors++; $display("FAIL rand_nop: got %h expected 00", bus.op); end
      end
      checks++; if (retire_cnt !== CNT_W'(m_cnt) || retire_cnt_s !== CNT_S_W'(m_cnt)) begin errors++; $display("FAIL rand_cnt: got %0d/%0d expected %0d", retire_cnt, retire_cnt_s, m_cnt); end
      r = ($urandom_range(0, 1) == 1);
      j = ($urandom_range(0, 3) == 0);
      b = ($urandom_range(0, 2) == 0);
      z = ($urandom_range(0, 1) == 1);
      bus.ins_ready = r;
      bus.jump      = j;
      bus.branch    = b;
      bus.acc_zero  = z;
      if (bus.ins_valid === 1'b1 && r) begin
        if (j || (b && z)) m_pc = w[7:0];
        else               m_pc = m_pc + 8'd1;
        m_cnt++;
        retired++;
      end
    end
    checks++; if (retired < 200) begin errors++; $display("FAIL rand_progress: retired %0d expected 200 within budget", retired); end
    mem_rand = 0;
    drive_idle();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    drive_idle();
    test_reset();
    test_basic();
    test_ack_delay();
    test_stall();
    test_redirect();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
